// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with enable: routes data to the lane chosen by sel, zeroes the rest.
// Define DEMUX_1TO4_REG_OUT_EN to add a one-cycle output register with async active-low clear.
module demux_1to4 #(
  parameter int DATA_W = 1
) (
  output logic [4*DATA_W-1:0] out,
  input  logic [1:0]          sel,
  input  logic [DATA_W-1:0]   data,
  input  logic                enable,
  input  logic                clk,
  input  logic                rst_n
);

  logic [4*DATA_W-1:0] w_lanes;

  // NOTE: every lane gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    w_lanes = '0;
    for (int i = 0; i < 4; i++) begin
      if (enable && (sel == 2'(i))) begin
        w_lanes[i*DATA_W +: DATA_W] = data;
      end
    end
  end

`ifdef DEMUX_1TO4_REG_OUT_EN
  logic [4*DATA_W-1:0] r_out;

  // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_lanes;
    end
  end

  assign out = r_out;
`else
  // The clock and reset are kept on the port list for a uniform footprint but have no load here.
  logic w_unused;
  assign w_unused = clk ^ rst_n;

  assign out = w_lanes;
`endif

endmodule

// File: tb/tb_demux_1to4.sv
// Directed and random checks for demux_1to4 at DATA_W=1 and DATA_W=8.
// Works in both the combinational build and the DEMUX_1TO4_REG_OUT_EN build.
module tb_demux_1to4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] out1;
  logic [1:0] sel1 = 2'd0;
  logic       data1 = 1'b0;
  logic       en1 = 1'b0;

  logic [31:0] out8;
  logic [1:0]  sel8 = 2'd0;
  logic [7:0]  data8 = 8'h00;
  logic        en8 = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  demux_1to4 #(.DATA_W(1)) u_dut1 (
    .out(out1), .sel(sel1), .data(data1), .enable(en1), .clk(clk), .rst_n(rst_n)
  );

  demux_1to4 #(.DATA_W(8)) u_dut8 (
    .out(out8), .sel(sel8), .data(data8), .enable(en8), .clk(clk), .rst_n(rst_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Let the inputs take effect: a short delay when combinational, one capture edge when registered.
  task automatic settle();
`ifdef DEMUX_1TO4_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  function automatic logic [3:0] model1(input logic [1:0] s, input logic d, input logic e);
    case ({e, d})
      2'b11:   model1 = 4'b0001 << s;
      default: model1 = 4'b0000;
    endcase
  endfunction

  initial begin
    // Reset state: inputs would select lane 1, but registered output must hold 0 while reset is low.
    en1 = 1'b1; data1 = 1'b1; sel1 = 2'd1;
    #2;
`ifdef DEMUX_1TO4_REG_OUT_EN
    check("reset_hold", {28'b0, out1}, 32'h0);
    @(posedge clk); #1;
    check("reset_hold_edge", {28'b0, out1}, 32'h0);
`else
    check("comb_ignores_reset", {28'b0, out1}, 32'h2);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    en1 = 1'b0; data1 = 1'b0; sel1 = 2'd0;
    settle();

    // Enable-off sweep.
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 4; s++) begin
        en1 = 1'b0; data1 = d[0]; sel1 = s[1:0];
        settle();
        check($sformatf("en0_d%0d_s%0d", d, s), {28'b0, out1}, 32'h0);
      end
    end

    // Enable-on, data zero.
    for (int s = 0; s < 4; s++) begin
      en1 = 1'b1; data1 = 1'b0; sel1 = s[1:0];
      settle();
      check($sformatf("en1_d0_s%0d", s), {28'b0, out1}, 32'h0);
    end

    // Enable-on, data one: hand-computed one-hot lanes.
    en1 = 1'b1; data1 = 1'b1;
    sel1 = 2'd0; settle(); check("en1_d1_s0", {28'b0, out1}, 32'h1);
    sel1 = 2'd1; settle(); check("en1_d1_s1", {28'b0, out1}, 32'h2);
    sel1 = 2'd2; settle(); check("en1_d1_s2", {28'b0, out1}, 32'h4);
    sel1 = 2'd3; settle(); check("en1_d1_s3", {28'b0, out1}, 32'h8);

    // Random vectors: result must be zero or one-hot at index sel, and only when enable and data are 1.
    for (int k = 0; k < 1000; k++) begin
      sel1  = 2'($urandom_range(3));
      data1 = 1'($urandom_range(1));
      en1   = 1'($urandom_range(1));
      settle();
      check($sformatf("rand_%0d", k), {28'b0, out1}, {28'b0, model1(sel1, data1, en1)});
    end

    // Wide data lane placement.
    en8 = 1'b1; data8 = 8'hA5; sel8 = 2'd2;
    settle();
    check("wide_s2", out8, 32'h00A5_0000);
    en8 = 1'b0;
    settle();
    check("wide_en0", out8, 32'h0);
    en8 = 1'b1; data8 = 8'h3C; sel8 = 2'd3;
    settle();
    check("wide_s3", out8, 32'h3C00_0000);

`ifdef DEMUX_1TO4_REG_OUT_EN
    // One-cycle latency: clear the register, then present lane 3 between edges.
    en1 = 1'b0;
    @(posedge clk); #1;
    en1 = 1'b1; data1 = 1'b1; sel1 = 2'd3;
    #1;
    check("reg_before_edge", {28'b0, out1}, 32'h0);
    @(posedge clk); #1;
    check("reg_after_edge", {28'b0, out1}, 32'h8);

    // Asynchronous clear between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_clear", {28'b0, out1}, 32'h0);
    @(posedge clk); #1;
    check("reg_hold_low", {28'b0, out1}, 32'h0);

    // Release away from an edge; output stays 0 until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reg_released_wait", {28'b0, out1}, 32'h0);
    @(posedge clk); #1;
    check("reg_first_capture", {28'b0, out1}, 32'h8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
